// File: rtl/rip_branch_resolver_if.sv
// Bundle between fetch/execute and the branch resolver.
// The slave modport is the resolver; the master modport is the pipeline side.
interface rip_branch_resolver_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 10,
    parameter int unsigned WT_W  = 2
);
    logic                     push;
    logic [IDX_W-1:0]         push_index;
    logic [WT_W-1:0]          push_weight;
    logic                     push_pred;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     stall;
    logic                     resolve;
    logic                     resolve_taken;
    logic                     flush;
    logic                     update;
    logic [IDX_W-1:0]         update_index;
    logic [WT_W-1:0]          update_weight;
    logic                     actual;
    logic                     mispredict;
    logic                     overflow;
    logic [31:0]              stat_resolved;
    logic [31:0]              stat_mispred;

    modport master (
        output push, push_index, push_weight, push_pred, stall, resolve, resolve_taken, flush,
        input  full, empty, count, update, update_index, update_weight, actual, mispredict,
        input  overflow, stat_resolved, stat_mispred
    );

    modport slave (
        input  push, push_index, push_weight, push_pred, stall, resolve, resolve_taken, flush,
        output full, empty, count, update, update_index, update_weight, actual, mispredict,
        output overflow, stat_resolved, stat_mispred
    );
endinterface

// File: rtl/rip_branch_resolver.sv
// In-order tracker of in-flight branch predictions; returns predictor updates oldest-first.
// Optional statistics counters are built when RIP_BR_RESOLVER_STATS_EN is defined.
module rip_branch_resolver #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 10,
    parameter int unsigned WT_W  = 2
) (
    input logic                  clk,
    input logic                  rst,
    rip_branch_resolver_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = IDX_W + WT_W + 1;

    // Entry layout: {index, weight, pred}
    logic [EW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [EW-1:0]    head;
    logic             head_pred;
    logic [WT_W-1:0]  head_weight;
    logic [IDX_W-1:0] head_index;
    logic             empty, full;
    logic             acc_res, acc_push, mis, kill;

    logic             update_q, mispredict_q, actual_q, overflow_q;
    logic [IDX_W-1:0] update_index_q;
    logic [WT_W-1:0]  update_weight_q;

    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign head_pred   = head[0];
    assign head_weight = head[WT_W:1];
    assign head_index  = head[EW-1:WT_W+1];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    always_comb begin
        acc_res  = bus.resolve & ~bus.stall & ~empty;
        mis      = acc_res & (head_pred != bus.resolve_taken);
        kill     = bus.flush | mis;
        // A same-cycle pop frees the head slot, so a push is accepted even when full.
        acc_push = bus.push & ~kill & (~full | acc_res);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (kill) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (acc_res)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (acc_push) wr_ptr_d = wr_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (acc_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {bus.push_index, bus.push_weight, bus.push_pred};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            update_q        <= 1'b0;
            mispredict_q    <= 1'b0;
            actual_q        <= 1'b0;
            overflow_q      <= 1'b0;
            update_index_q  <= '0;
            update_weight_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            update_q     <= acc_res;
            mispredict_q <= mis;
            if (bus.push && full && !acc_res) overflow_q <= 1'b1;
            if (acc_res) begin
                actual_q        <= bus.resolve_taken;
                update_index_q  <= head_index;
                update_weight_q <= head_weight;
            end
        end
    end

`ifdef RIP_BR_RESOLVER_STATS_EN
    logic [31:0] stat_resolved_q, stat_mispred_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (acc_res && (stat_resolved_q != 32'hFFFF_FFFF)) stat_resolved_q <= stat_resolved_q + 32'd1;
            if (mis && (stat_mispred_q != 32'hFFFF_FFFF))      stat_mispred_q  <= stat_mispred_q + 32'd1;
        end
    end

    assign bus.stat_resolved = stat_resolved_q;
    assign bus.stat_mispred  = stat_mispred_q;
`else
    assign bus.stat_resolved = 32'd0;
    assign bus.stat_mispred  = 32'd0;
`endif

    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.count         = wr_ptr_q - rd_ptr_q;
    assign bus.update        = update_q;
    assign bus.update_index  = update_index_q;
    assign bus.update_weight = update_weight_q;
    assign bus.actual        = actual_q;
    assign bus.mispredict    = mispredict_q;
    assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_rip_branch_resolver.sv
// Directed bench for rip_branch_resolver (DEPTH=8, IDX_W=10, WT_W=2).
module tb_rip_branch_resolver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    rip_branch_resolver_if #(.DEPTH(8), .IDX_W(10), .WT_W(2)) bus ();

    rip_branch_resolver #(.DEPTH(8), .IDX_W(10), .WT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [9:0] idx, input logic [1:0] wt, input logic pred);
        bus.push        = 1'b1;
        bus.push_index  = idx;
        bus.push_weight = wt;
        bus.push_pred   = pred;
        tick();
        bus.push = 1'b0;
    endtask

    task automatic resolve1(input logic taken);
        bus.resolve       = 1'b1;
        bus.resolve_taken = taken;
        tick();
        bus.resolve = 1'b0;
    endtask

    task automatic expect_update(input string tag, input logic [9:0] idx, input logic [1:0] wt,
                                 input logic act, input logic mis);
        check({tag, ".update"},     32'(bus.update), 32'd1);
        check({tag, ".index"},      32'(bus.update_index), 32'(idx));
        check({tag, ".weight"},     32'(bus.update_weight), 32'(wt));
        check({tag, ".actual"},     32'(bus.actual), 32'(act));
        check({tag, ".mispredict"}, 32'(bus.mispredict), 32'(mis));
    endtask

    task automatic check_stats(input string tag, input int res, input int mis);
`ifdef RIP_BR_RESOLVER_STATS_EN
        check({tag, ".stat_resolved"}, bus.stat_resolved, 32'(res));
        check({tag, ".stat_mispred"},  bus.stat_mispred,  32'(mis));
`else
        check({tag, ".stat_resolved"}, bus.stat_resolved, 32'd0);
        check({tag, ".stat_mispred"},  bus.stat_mispred,  32'd0);
`endif
    endtask

    initial begin
        bus.push          = 1'b0;
        bus.push_index    = '0;
        bus.push_weight   = '0;
        bus.push_pred     = 1'b0;
        bus.stall         = 1'b0;
        bus.resolve       = 1'b0;
        bus.resolve_taken = 1'b0;
        bus.flush         = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst.empty",    32'(bus.empty), 32'd1);
        check("rst.full",     32'(bus.full), 32'd0);
        check("rst.count",    32'(bus.count), 32'd0);
        check("rst.update",   32'(bus.update), 32'd0);
        check("rst.mispred",  32'(bus.mispredict), 32'd0);
        check("rst.overflow", 32'(bus.overflow), 32'd0);
        check("rst.index",    32'(bus.update_index), 32'd0);
        check_stats("rst", 0, 0);

        // Three pushes, three taken resolves; the 2nd mispredicts and kills the 3rd entry
        push1(10'd5, 2'd2, 1'b1);
        push1(10'd9, 2'd1, 1'b0);
        push1(10'd3, 2'd3, 1'b1);
        check("seq.count3", 32'(bus.count), 32'd3);
        resolve1(1'b1);
        expect_update("seq.r1", 10'd5, 2'd2, 1'b1, 1'b0);
        check("seq.count2", 32'(bus.count), 32'd2);
        resolve1(1'b1);
        expect_update("seq.r2", 10'd9, 2'd1, 1'b1, 1'b1);
        check("seq.empty", 32'(bus.empty), 32'd1);
        check("seq.count0", 32'(bus.count), 32'd0);
        resolve1(1'b1);
        check("seq.r3.update", 32'(bus.update), 32'd0);
        check("seq.r3.hold", 32'(bus.update_index), 32'd9);
        check_stats("seq", 2, 1);

        // Fill, overflow, then push+resolve bypass while full
        for (int i = 0; i < 8; i++) push1(10'(16 + i), 2'(i % 4), 1'b1);
        check("fill.count", 32'(bus.count), 32'd8);
        check("fill.full", 32'(bus.full), 32'd1);
        push1(10'd99, 2'd3, 1'b1);
        check("ovf.flag", 32'(bus.overflow), 32'd1);
        check("ovf.count", 32'(bus.count), 32'd8);
        bus.push          = 1'b1;
        bus.push_index    = 10'd100;
        bus.push_weight   = 2'd0;
        bus.push_pred     = 1'b1;
        bus.resolve       = 1'b1;
        bus.resolve_taken = 1'b1;
        tick();
        bus.push    = 1'b0;
        bus.resolve = 1'b0;
        expect_update("byp", 10'd16, 2'd0, 1'b1, 1'b0);
        check("byp.count", 32'(bus.count), 32'd8);
        check("byp.full", 32'(bus.full), 32'd1);
        for (int k = 0; k < 7; k++) begin
            resolve1(1'b1);
            expect_update($sformatf("pop%0d", k), 10'(17 + k), 2'((1 + k) % 4), 1'b1, 1'b0);
        end
        resolve1(1'b1);
        expect_update("pop7", 10'd100, 2'd0, 1'b1, 1'b0);
        check("pop.empty", 32'(bus.empty), 32'd1);
        check_stats("pop", 11, 1);

        // Mispredict with a simultaneous push: queue empties, pushed entry is lost
        for (int i = 0; i < 4; i++) push1(10'(40 + i), 2'd1, 1'b1);
        bus.push          = 1'b1;
        bus.push_index    = 10'd50;
        bus.push_weight   = 2'd2;
        bus.push_pred     = 1'b0;
        bus.resolve       = 1'b1;
        bus.resolve_taken = 1'b0;
        tick();
        bus.push    = 1'b0;
        bus.resolve = 1'b0;
        expect_update("mis", 10'd40, 2'd1, 1'b0, 1'b1);
        check("mis.count", 32'(bus.count), 32'd0);
        check("mis.empty", 32'(bus.empty), 32'd1);
        tick();
        check("mis.pulse_end", 32'(bus.update), 32'd0);
        push1(10'd60, 2'd3, 1'b1);
        check("mis.count1", 32'(bus.count), 32'd1);
        resolve1(1'b1);
        expect_update("mis.next", 10'd60, 2'd3, 1'b1, 1'b0);

        // Stall and resolve-on-empty are ignored
        push1(10'd70, 2'd0, 1'b0);
        push1(10'd71, 2'd1, 1'b0);
        bus.stall = 1'b1;
        resolve1(1'b0);
        bus.stall = 1'b0;
        check("stall.update", 32'(bus.update), 32'd0);
        check("stall.count", 32'(bus.count), 32'd2);
        resolve1(1'b0);
        expect_update("st.r1", 10'd70, 2'd0, 1'b0, 1'b0);
        resolve1(1'b0);
        expect_update("st.r2", 10'd71, 2'd1, 1'b0, 1'b0);
        resolve1(1'b0);
        check("empres.update", 32'(bus.update), 32'd0);
        check("empres.empty", 32'(bus.empty), 32'd1);
        push1(10'd80, 2'd2, 1'b0);
        resolve1(1'b0);
        expect_update("empres.next", 10'd80, 2'd2, 1'b0, 1'b0);
        check_stats("empres", 16, 2);

        // Flush with a same-cycle correct resolve
        push1(10'd90, 2'd1, 1'b1);
        push1(10'd91, 2'd2, 1'b1);
        push1(10'd92, 2'd3, 1'b1);
        bus.flush         = 1'b1;
        bus.resolve       = 1'b1;
        bus.resolve_taken = 1'b1;
        tick();
        bus.flush   = 1'b0;
        bus.resolve = 1'b0;
        expect_update("flush", 10'd90, 2'd1, 1'b1, 1'b0);
        check("flush.count", 32'(bus.count), 32'd0);
        check_stats("flush", 17, 2);

        // Reset mid-stream with a pending resolve
        push1(10'd11, 2'd1, 1'b1);
        push1(10'd12, 2'd2, 1'b0);
        rst               = 1'b1;
        bus.resolve       = 1'b1;
        bus.resolve_taken = 1'b0;
        tick();
        rst         = 1'b0;
        bus.resolve = 1'b0;
        check("mrst.update",   32'(bus.update), 32'd0);
        check("mrst.mispred",  32'(bus.mispredict), 32'd0);
        check("mrst.count",    32'(bus.count), 32'd0);
        check("mrst.empty",    32'(bus.empty), 32'd1);
        check("mrst.overflow", 32'(bus.overflow), 32'd0);
        check("mrst.index",    32'(bus.update_index), 32'd0);
        check("mrst.weight",   32'(bus.update_weight), 32'd0);
        check("mrst.actual",   32'(bus.actual), 32'd0);
        check_stats("mrst", 0, 0);

        // Ten resolves, the first four mispredicted
        for (int i = 0; i < 10; i++) begin
            push1(10'(200 + i), 2'(i % 4), (i < 4) ? 1'b0 : 1'b1);
            resolve1(1'b1);
            expect_update($sformatf("st10.%0d", i), 10'(200 + i), 2'(i % 4), 1'b1,
                          (i < 4) ? 1'b1 : 1'b0);
        end
        check_stats("st10", 10, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
